// File: rtl/multi_key_debouncer.sv
// Multi-channel key debouncer: 2-flop sync, FILT_LEN-sample hysteresis
// filter and per-channel auto-repeat (IDLE -> DELAY -> REPEAT).
// Ports: CLK, CLR (async, active-high), CE (filter sample enable),
//   REP_CE (repeat tick enable), S_IN[CH_NUM] raw keys (1 = pressed);
//   KEY_EN debounced state, KEY_UP press/repeat pulse,
//   KEY_REL release pulse, KEY_ANY = OR of KEY_EN.
// Option: define MULTI_KEY_DEBOUNCER_ACCEL_EN to halve the repeat
//   period (min 1) after ACCEL_AFTER repeats.
module multi_key_debouncer #(
   parameter int CH_NUM      = 4,
   parameter int FILT_LEN    = 4,
   parameter int REP_DELAY   = 50,
   parameter int REP_PERIOD  = 10,
   parameter int ACCEL_AFTER = 8
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              CE,
   input  logic              REP_CE,
   input  logic [CH_NUM-1:0] S_IN,
   output logic [CH_NUM-1:0] KEY_EN,
   output logic [CH_NUM-1:0] KEY_UP,
   output logic [CH_NUM-1:0] KEY_REL,
   output logic              KEY_ANY
);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   localparam logic [7:0] DLY_LD = 8'(REP_DELAY - 1);
   localparam logic [7:0] PER_LD = 8'(REP_PERIOD - 1);

   if (CH_NUM < 1 || CH_NUM > 16 ||
       FILT_LEN < 2 || FILT_LEN > 16 ||
       REP_DELAY < 1 || REP_DELAY > 255 ||
       REP_PERIOD < 1 || REP_PERIOD > 255 ||
       ACCEL_AFTER < 1 || ACCEL_AFTER > 255) begin : g_bad_param
      $error("multi_key_debouncer: parameter out of range");
   end

   logic [CH_NUM-1:0]   sync1_q, sync2_q;
   logic [FILT_LEN-1:0] hist_q [CH_NUM];
   logic [FILT_LEN-1:0] hist_d [CH_NUM];
   logic [CH_NUM-1:0]   en_q, en_d;
   logic [CH_NUM-1:0]   up_q, up_d;
   logic [CH_NUM-1:0]   rel_q, rel_d;
   logic [CH_NUM-1:0]   rise, fall, tick, expire;
   state_t              st_q [CH_NUM];
   state_t              st_d [CH_NUM];
   logic [7:0]          cnt_q [CH_NUM];
   logic [7:0]          cnt_d [CH_NUM];
   logic [7:0]          per_ld [CH_NUM];

   // Filter: the freshly shifted history decides, so KEY_EN moves on
   // the same edge that completes a run of equal samples.
   always_comb begin
      en_d = en_q;
      for (int i = 0; i < CH_NUM; i++) begin
         hist_d[i] = hist_q[i];
         if (CE) begin
            hist_d[i] = {hist_q[i][FILT_LEN-2:0], sync2_q[i]};
            if (&hist_d[i])
               en_d[i] = 1'b1;
            else if (~|hist_d[i])
               en_d[i] = 1'b0;
         end
      end
      rise = en_d & ~en_q;
      fall = ~en_d & en_q;
   end

   // Repeat ticks only count while pressed; a release on the same
   // edge pre-empts any expiry.
   always_comb begin
      tick   = '0;
      expire = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         tick[i]   = REP_CE && (st_q[i] != IDLE) && !fall[i];
         expire[i] = tick[i] && (cnt_q[i] == 8'd0);
      end
   end

`ifdef MULTI_KEY_DEBOUNCER_ACCEL_EN
   localparam int FAST = (REP_PERIOD / 2 > 1) ? REP_PERIOD / 2 : 1;
   localparam logic [7:0] FAST_LD = 8'(FAST - 1);
   localparam logic [7:0] ACC_N   = 8'(ACCEL_AFTER);

   logic [7:0] rc_q [CH_NUM];
   logic [7:0] rc_d [CH_NUM];

   // Saturating repeat count; the period reloaded at an expiry uses
   // the count including that expiry.
   always_comb begin
      logic [7:0] inc;
      inc = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         inc       = (rc_q[i] < ACC_N) ? rc_q[i] + 8'd1 : rc_q[i];
         per_ld[i] = (inc >= ACC_N) ? FAST_LD : PER_LD;
         rc_d[i]   = rc_q[i];
         if (fall[i] || rise[i])
            rc_d[i] = '0;
         else if (expire[i])
            rc_d[i] = inc;
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < CH_NUM; i++)
            rc_q[i] <= '0;
      end else begin
         for (int i = 0; i < CH_NUM; i++)
            rc_q[i] <= rc_d[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < CH_NUM; i++)
         per_ld[i] = PER_LD;
   end
`endif

   // State register
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         sync1_q <= '0;
         sync2_q <= '0;
         en_q    <= '0;
         up_q    <= '0;
         rel_q   <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            hist_q[i] <= '0;
            st_q[i]   <= IDLE;
            cnt_q[i]  <= '0;
         end
      end else begin
         sync1_q <= S_IN;
         sync2_q <= sync1_q;
         en_q    <= en_d;
         up_q    <= up_d;
         rel_q   <= rel_d;
         for (int i = 0; i < CH_NUM; i++) begin
            hist_q[i] <= hist_d[i];
            st_q[i]   <= st_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   // Next state
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         unique case (1'b1)
            fall[i]: begin
               st_d[i]  = IDLE;
               cnt_d[i] = '0;
            end
            rise[i]: begin
               st_d[i]  = DELAY;
               cnt_d[i] = DLY_LD;
            end
            tick[i]: begin
               if (cnt_q[i] == 8'd0) begin
                  st_d[i]  = REPEAT;
                  cnt_d[i] = per_ld[i];
               end else begin
                  cnt_d[i] = cnt_q[i] - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs (registered through up_q / rel_q)
   always_comb begin
      up_d  = rise | expire;
      rel_d = fall;
   end

   assign KEY_EN  = en_q;
   assign KEY_UP  = up_q;
   assign KEY_REL = rel_q;
   assign KEY_ANY = |en_q;

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Self-checking bench for multi_key_debouncer: vector table, directed
// corner sequences and randomized run against a behavioural model.
module tb_multi_key_debouncer;

   localparam int CH = 4;
   localparam int FL = 4;
   localparam int RD = 50;
   localparam int RP = 10;
   localparam int AA = 8;

   logic          CLK = 1'b0;
   logic          CLR = 1'b0;
   logic          CE = 1'b1;
   logic          REP_CE = 1'b1;
   logic [CH-1:0] S_IN = '0;
   logic [CH-1:0] KEY_EN, KEY_UP, KEY_REL;
   logic          KEY_ANY;

   int n_cmp = 0;
   int n_bad = 0;

   multi_key_debouncer #(
      .CH_NUM(CH), .FILT_LEN(FL), .REP_DELAY(RD),
      .REP_PERIOD(RP), .ACCEL_AFTER(AA)
   ) dut (
      .CLK(CLK), .CLR(CLR), .CE(CE), .REP_CE(REP_CE),
      .S_IN(S_IN), .KEY_EN(KEY_EN), .KEY_UP(KEY_UP),
      .KEY_REL(KEY_REL), .KEY_ANY(KEY_ANY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] s;
      logic [3:0] en;
      logic [3:0] up;
      logic [3:0] rel;
   } vec_t;

   vec_t tbl [20];

   // Behavioural model: raw samples delayed two edges, run length of
   // equal samples, ticks elapsed since press vs. next repeat time.
   bit md1 [CH];
   bit md2 [CH];
   bit mlast [CH];
   bit mkey [CH];
   bit mup [CH];
   bit mrel [CH];
   int mrun [CH];
   int mticks [CH];
   int mnext [CH];
   int mnrep [CH];

   function automatic int period(input int nrep);
`ifdef MULTI_KEY_DEBOUNCER_ACCEL_EN
      int fast;
      fast = (RP / 2 > 1) ? RP / 2 : 1;
      return (nrep >= AA) ? fast : RP;
`else
      return (nrep >= 0) ? RP : RP;
`endif
   endfunction

   function automatic void m_reset();
      for (int ch = 0; ch < CH; ch++) begin
         md1[ch] = 0;  md2[ch] = 0;
         mlast[ch] = 0; mkey[ch] = 0;
         mup[ch] = 0;  mrel[ch] = 0;
         mrun[ch] = FL; mticks[ch] = 0;
         mnext[ch] = 0; mnrep[ch] = 0;
      end
   endfunction

   function automatic void m_step();
      bit samp;
      bit chg;
      if (CLR) begin
         m_reset();
         return;
      end
      for (int ch = 0; ch < CH; ch++) begin
         samp = md2[ch];
         chg = 0;
         mup[ch] = 0;
         mrel[ch] = 0;
         if (CE) begin
            if (samp == mlast[ch]) begin
               if (mrun[ch] < FL) mrun[ch]++;
            end else begin
               mrun[ch] = 1;
               mlast[ch] = samp;
            end
            if (mrun[ch] >= FL && mkey[ch] != mlast[ch]) begin
               mkey[ch] = mlast[ch];
               chg = 1;
               if (mkey[ch]) begin
                  mup[ch] = 1;
                  mticks[ch] = 0;
                  mnext[ch] = RD;
                  mnrep[ch] = 0;
               end else begin
                  mrel[ch] = 1;
               end
            end
         end
         if (!chg && mkey[ch] && REP_CE) begin
            mticks[ch]++;
            if (mticks[ch] == mnext[ch]) begin
               mup[ch] = 1;
               mnrep[ch]++;
               mnext[ch] += period(mnrep[ch]);
            end
         end
         md2[ch] = md1[ch];
         md1[ch] = S_IN[ch];
      end
   endfunction

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] en,
                          input logic [3:0] up, input logic [3:0] rel);
      chk({tag, ".en"}, KEY_EN, en);
      chk({tag, ".up"}, KEY_UP, up);
      chk({tag, ".rel"}, KEY_REL, rel);
      chk({tag, ".any"}, {3'b000, KEY_ANY}, {3'b000, |en});
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      m_step();
   endtask

   task automatic drain(input int n);
      S_IN = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_clr(input string tag);
      CLR = 1'b1;
      #2;
      chk_all({tag, "_async"}, 4'b0000, 4'b0000, 4'b0000);
      tick();
      chk_all({tag, "_held"}, 4'b0000, 4'b0000, 4'b0000);
      CLR = 1'b0;
   endtask

   initial begin
      logic [3:0] e_en, e_up, e_rel;
      logic [3:0] intent;

      // Bounce on channel 0, then hold, then release.
      tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[3]  = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[4]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[5]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[6]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[7]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[8]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{4'h1, 4'h1, 4'h1, 4'h0};
      tbl[10] = '{4'h1, 4'h1, 4'h0, 4'h0};
      tbl[11] = '{4'h1, 4'h1, 4'h0, 4'h0};
      tbl[12] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[13] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[14] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[15] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[16] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[17] = '{4'h0, 4'h0, 4'h0, 4'h1};
      tbl[18] = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[19] = '{4'h0, 4'h0, 4'h0, 4'h0};

      m_reset();
      #1;
      CLR = 1'b1;
      #2;
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000);
      tick();
      CLR = 1'b0;

      for (int r = 0; r < 20; r++) begin
         S_IN = tbl[r].s;
         tick();
         chk_all($sformatf("tbl%0d", r), tbl[r].en, tbl[r].up,
                 tbl[r].rel);
      end
      drain(5);

      // Long hold on channel 1; release lands on a repeat expiry.
      for (int c = 0; c < 120; c++) begin
         S_IN = (c < 100) ? 4'b0010 : 4'b0000;
         tick();
         e_en = (c >= 5 && c < 105) ? 4'b0010 : 4'b0000;
         e_up = (c == 5 || (c >= 55 && c <= 95 && (c - 55) % 10 == 0))
                ? 4'b0010 : 4'b0000;
         e_rel = (c == 105) ? 4'b0010 : 4'b0000;
         chk_all($sformatf("hold%0d", c), e_en, e_up, e_rel);
      end
      drain(5);

      // Channels 0 and 3 together, released at different times.
      for (int c = 0; c < 40; c++) begin
         S_IN = {c < 30, 2'b00, c < 20};
         tick();
         e_en = {c >= 5 && c < 35, 2'b00, c >= 5 && c < 25};
         e_up = (c == 5) ? 4'b1001 : 4'b0000;
         e_rel = {c == 35, 2'b00, c == 25};
         chk_all($sformatf("dual%0d", c), e_en, e_up, e_rel);
      end
      drain(5);

      // Reset while channel 2 is repeating; key stays held.
      for (int c = 0; c < 56; c++) begin
         S_IN = 4'b0100;
         tick();
         e_en = (c >= 5) ? 4'b0100 : 4'b0000;
         e_up = (c == 5 || c == 55) ? 4'b0100 : 4'b0000;
         chk_all($sformatf("pre_clr%0d", c), e_en, e_up, 4'b0000);
      end
      do_clr("clr");
      for (int k = 1; k <= 60; k++) begin
         tick();
         e_en = (k >= 6) ? 4'b0100 : 4'b0000;
         e_up = (k == 6 || k == 56) ? 4'b0100 : 4'b0000;
         chk_all($sformatf("post_clr%0d", k), e_en, e_up, 4'b0000);
      end
      drain(12);

`ifdef MULTI_KEY_DEBOUNCER_ACCEL_EN
      for (int c = 0; c < 141; c++) begin
         S_IN = 4'b0001;
         tick();
         e_en = (c >= 5) ? 4'b0001 : 4'b0000;
         e_up = (c == 5 ||
                 (c >= 55 && c <= 125 && (c - 55) % 10 == 0) ||
                 (c > 125 && (c - 125) % 5 == 0))
                ? 4'b0001 : 4'b0000;
         chk_all($sformatf("accel%0d", c), e_en, e_up, 4'b0000);
      end
      drain(12);
`endif

      // Randomized run against the model.
      do_clr("rclr");
      intent = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int ch = 0; ch < CH; ch++) begin
            if ($urandom_range(0, 149) == 0) intent[ch] = ~intent[ch];
            S_IN[ch] = intent[ch] ^ ($urandom_range(0, 9) == 0);
         end
         CE = ($urandom_range(0, 3) != 0);
         REP_CE = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 999) == 0) do_clr("rnd_clr");
         tick();
         for (int ch = 0; ch < CH; ch++) begin
            e_en[ch] = mkey[ch];
            e_up[ch] = mup[ch];
            e_rel[ch] = mrel[ch];
         end
         chk_all($sformatf("rnd%0d", c), e_en, e_up, e_rel);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_key_debouncer.md
MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of independent key channels (1..16).
REQ-002 SHALL have parameter FILT_LEN, default 4: consecutive equal CE samples needed to change debounced state (2..16).
REQ-003 SHALL have parameter REP_DELAY, default 50: REP_CE ticks from press to first repeat pulse (1..255).
REQ-004 SHALL have parameter REP_PERIOD, default 10: REP_CE ticks between repeat pulses (1..255).
REQ-005 SHALL have parameter ACCEL_AFTER, default 8: repeat pulses before accelerated period applies (1..255; used only with the macro in REQ-030).
REQ-006 SHALL have port CLK  input  1  clock, rising-edge.
REQ-007 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port CE  input  1  sample enable for input filtering.
REQ-009 SHALL have port REP_CE  input  1  tick enable for repeat counters.
REQ-010 SHALL have port S_IN  input  CH_NUM  raw key inputs, 1 = pressed, asynchronous to CLK.
REQ-011 SHALL have port KEY_EN  output  CH_NUM  debounced key state per channel.
REQ-012 SHALL have port KEY_UP  output  CH_NUM  one-CLK pulse per press and per repeat.
REQ-013 SHALL have port KEY_REL  output  CH_NUM  one-CLK pulse per release.
REQ-014 SHALL have port KEY_ANY  output  1  OR of all KEY_EN bits.

Function
REQ-015 Each channel SHALL pass S_IN through a 2-flop synchroniser, then shift it into a FILT_LEN-bit history register on CLK edges where CE=1.
REQ-016 KEY_EN[i] SHALL set when history is all ones and clear when history is all zeros; mixed history holds KEY_EN[i] (hysteresis).
REQ-017 KEY_EN[i], KEY_UP[i], KEY_REL[i] SHALL be registered; a press/release pulse SHALL rise on the same CLK edge that changes KEY_EN[i] and last exactly one CLK cycle.
REQ-018 Each channel SHALL run an FSM IDLE -> DELAY -> REPEAT with an 8-bit down-counter decremented only on REP_CE=1.
REQ-019 On press (KEY_EN 0->1): counter loads REP_DELAY-1, state DELAY.
REQ-020 In DELAY or REPEAT, REP_CE=1 with counter=0: KEY_UP[i] pulses one cycle, counter loads the active period minus 1, state REPEAT.
REQ-021 On release (KEY_EN 1->0) from any state: state IDLE, counter 0, no KEY_UP that cycle; release SHALL win over a simultaneous repeat expiry.
REQ-022 In IDLE, REP_CE SHALL have no effect; KEY_UP SHALL never assert while KEY_EN=0.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 CE=0 SHALL freeze histories and KEY_EN; REP_CE operation SHALL continue.
REQ-025 KEY_ANY SHALL be combinational OR of KEY_EN.

Reset
REQ-026 CLR=1 SHALL immediately force synchronisers, histories, KEY_EN, KEY_UP, KEY_REL, counters to 0 and all FSMs to IDLE, regardless of CLK.
REQ-027 A key held across CLR deassertion SHALL produce a fresh press pulse after FILT_LEN+2 CE samples; no release pulse SHALL result from the reset.
REQ-028 Reset mid-repeat SHALL discard pending repeat timing; next press restarts at REP_DELAY.

Configuration
REQ-029 Without MULTI_KEY_DEBOUNCER_ACCEL_EN the repeat period SHALL be constant REP_PERIOD.
REQ-030 With MULTI_KEY_DEBOUNCER_ACCEL_EN defined, each channel SHALL count repeat pulses (saturating at ACCEL_AFTER); once ACCEL_AFTER repeats occur, period SHALL become max(REP_PERIOD/2 integer, 1); release or CLR SHALL clear the count.

Verification (CE=REP_CE=1 every cycle unless stated, defaults)
REQ-031 Bounce S_IN[0] 1,0,1,0,1 then hold 1 -> KEY_EN[0] rises 2+4 cycles after stable 1 begins, single KEY_UP[0] pulse, none during bounce.
REQ-032 Hold S_IN[1]=1 for 100 cycles -> KEY_UP[1] at press, then press+50, +60, +70, +80, +90; release -> one KEY_REL[1], FSM IDLE.
REQ-033 Release timed to coincide with repeat expiry -> KEY_REL pulse, no KEY_UP that cycle.
REQ-034 Press channels 0 and 3 on the same cycle -> KEY_UP[0] and KEY_UP[3] same cycle, KEY_ANY=1 until both released.
REQ-035 Assert CLR for 1 cycle while key held in REPEAT -> all outputs 0 immediately, new press pulse after 6 cycles, first repeat 50 ticks later.
REQ-036 With MULTI_KEY_DEBOUNCER_ACCEL_EN, hold key -> repeats 1..8 spaced 10 ticks, repeats 9 onward spaced 5 ticks.
